ultrasound_burst_seq: RTL
=========================

// Module: ultrasound_burst_seq
// PURPOSE
//   Multi-shot, multi-channel ultrasound TX/acquisition sequencer. Generalises the single-shot
//   TX/ADC-window FSM: one START now runs NUM_SHOTS repetitions at a fixed pulse-repetition interval.
//   Each shot drives a channel-masked TX burst, then opens a FIFO_EN acquisition window for the ADC FIFO.
//   Sits between the host control registers and the TX drivers / ADC-FIFO write path.
// PARAMETERS
//   CNT_WIDTH   32  width of all cycle-count inputs and the internal shot-time counter
//   SHOT_WIDTH  16  width of NUM_SHOTS and SHOT_IDX
//   TX_CH       4   number of transmit channels (width of TX_EN and TX_CH_MASK)
// PORTS
//   CLK                   in   1           system clock
//   RESET                 in   1           synchronous, active-high reset
//   START                 in   1           level request; also the DONE handshake
//   TX_LEN                in   CNT_WIDTH   TX_EN pulse length in cycles (0 treated as 1)
//   TX_CH_MASK            in   TX_CH       channels fired each shot
//   ADC_INIT_DELAY        in   CNT_WIDTH   cycles from first TX cycle to window start
//   ADC_SAMPLES_PER_ECHO  in   CNT_WIDTH   window length in cycles (0 = no window)
//   SHOT_INTERVAL         in   CNT_WIDTH   cycles from one shot's first TX cycle to the next
//   NUM_SHOTS             in   SHOT_WIDTH  shots per run (0 treated as 1)
//   FIFO_FULL             in   1           ADC FIFO full flag
//   TX_EN                 out  TX_CH       per-channel transmit enable
//   ADC_START             out  1           1-cycle pulse on the first FIFO_EN cycle of each window
//   FIFO_EN               out  1           acquisition window, FIFO write enable
//   SHOT_IDX              out  SHOT_WIDTH  index of current shot, 0-based
//   BUSY                  out  1           high from the first TX cycle until DONE rises
//   DONE                  out  1           run complete, held until START low
//   OVERFLOW              out  1           sticky: FIFO_FULL seen while FIFO_EN high
// BEHAVIOUR
//   - All outputs registered. RESET (any state, mid-shot included) -> next edge: IDLE, all outputs 0,
//     shadow registers cleared.
//   - States: IDLE, TX, DELAY, ACQ, WAIT, FINISH. t = shot-time counter, 0 on each shot's first TX cycle.
//   - IDLE: START sampled high at edge k -> latch all config inputs into shadow registers; clear
//     OVERFLOW and SHOT_IDX. From k+1: state TX, BUSY=1, TX_EN=TX_CH_MASK. Inputs may change mid-run;
//     only shadows are used.
//   - TX: TX_EN=mask for t in [0, L). L = max(TX_LEN,1).
//   - DELAY: all enables low until t = W. W = max(ADC_INIT_DELAY, L). Skipped when W = L.
//   - ACQ: FIFO_EN=1 for t in [W, W+N). N = ADC_SAMPLES_PER_ECHO. ADC_START=1 at t = W only.
//     N = 0: no ACQ cycle, no ADC_START pulse.
//   - Last-shot test: SHOT_IDX = max(NUM_SHOTS,1)-1 -> FINISH at t = W+N.
//   - Other shots: WAIT until t = SHOT_INTERVAL, then SHOT_IDX+1 and a new TX cycle with t = 0.
//     If W+N >= SHOT_INTERVAL, the next shot starts at t = W+N (no WAIT cycle).
//   - FINISH: DONE=1, BUSY=0. Stays until START sampled low; DONE=0 and IDLE on the next edge.
//     START held high does not retrigger.
//   - OVERFLOW set on any cycle with FIFO_EN & FIFO_FULL. The sequence continues regardless.
//   - t saturates at all-ones; it never wraps. SHOT_IDX holds its last value until the next run.
// CONFIGURATION
//   ULTRASOUND_SEQ_ABORT_EN defined:
//     - Adds input ABORT (1 bit). ABORT high in TX/DELAY/ACQ/WAIT -> next edge: TX_EN=0, FIFO_EN=0,
//       BUSY=0, state FINISH, DONE=1.
//     - Adds output ABORTED (1 bit), set on abort and cleared at run start.
//     - ABORT is ignored in IDLE and FINISH. ABORT coincident with the last ACQ cycle -> abort wins.
//   Undefined: no ABORT/ABORTED ports; every run completes all shots.
// TESTING
//   1 Single shot, TX_LEN=5, DELAY=10, N=10, INTERVAL=40, NUM=1, MASK=4'b1011 ->
//     TX_EN=1011 for 5 cycles, ADC_START at t=10, FIFO_EN for 10 cycles, DONE at t=20.
//   2 Same settings, NUM=3 -> TX bursts at t=0,40,80; SHOT_IDX 0,1,2; exactly 30 FIFO_EN cycles;
//     DONE at t=100; DONE drops 1 cycle after START low.
//   3 TX_LEN=8, DELAY=3, N=0, INTERVAL=5, NUM=2 -> window start clamps to t=8, no FIFO_EN/ADC_START,
//     shot 2 TX at t=8, DONE at t=16.
//   4 FIFO_FULL=1 during the 4th window cycle -> OVERFLOW=1 sticky through DONE, cleared at next START.
//   5 RESET pulsed in shot 2 ACQ -> next edge all outputs 0, IDLE; START high again restarts at SHOT_IDX=0.
//   6 (ABORT_EN) ABORT at t=12 of shot 1, NUM=4 -> FIFO_EN low next edge, DONE=1, ABORTED=1, SHOT_IDX=0.

Source files
------------

// File: rtl/ultrasound_burst_seq.sv
// ultrasound_burst_seq: multi-shot TX burst / ADC window sequencer; optional ABORT via ULTRASOUND_SEQ_ABORT_EN
module ultrasound_burst_seq #(
    parameter int CNT_WIDTH  = 32,
    parameter int SHOT_WIDTH = 16,
    parameter int TX_CH      = 4
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  START,
    input  logic [CNT_WIDTH-1:0]  TX_LEN,
    input  logic [TX_CH-1:0]      TX_CH_MASK,
    input  logic [CNT_WIDTH-1:0]  ADC_INIT_DELAY,
    input  logic [CNT_WIDTH-1:0]  ADC_SAMPLES_PER_ECHO,
    input  logic [CNT_WIDTH-1:0]  SHOT_INTERVAL,
    input  logic [SHOT_WIDTH-1:0] NUM_SHOTS,
    input  logic                  FIFO_FULL,
`ifdef ULTRASOUND_SEQ_ABORT_EN
    input  logic                  ABORT,
    output logic                  ABORTED,
`endif
    output logic [TX_CH-1:0]      TX_EN,
    output logic                  ADC_START,
    output logic                  FIFO_EN,
    output logic [SHOT_WIDTH-1:0] SHOT_IDX,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  OVERFLOW
);
    typedef enum logic [2:0] {IDLE, TX, DELAY, ACQ, WAIT, FINISH} state_t;

    state_t                state, state_n;
    logic [CNT_WIDTH-1:0]  t, t_n, x;
    logic [SHOT_WIDTH-1:0] idx_n;
    logic                  load, abort_hit;

    // shadow copies of the run configuration, captured at START
    logic [CNT_WIDTH-1:0]  l_s, w_s, si_s;
    logic [CNT_WIDTH:0]    wn_s;
    logic [TX_CH-1:0]      mask_s;
    logic [SHOT_WIDTH-1:0] last_s;

    logic [CNT_WIDTH-1:0]  l_in, w_in;

    assign l_in = (TX_LEN == '0) ? CNT_WIDTH'(1) : TX_LEN;
    assign w_in = (ADC_INIT_DELAY > l_in) ? ADC_INIT_DELAY : l_in;

    // next state: the phase of a shot is decoded purely from the next shot-time value
    always_comb begin
        x         = (&t) ? t : t + 1'b1;
        state_n   = state;
        t_n       = t;
        idx_n     = SHOT_IDX;
        load      = 1'b0;
        abort_hit = 1'b0;
        case (state)
            IDLE: begin
                if (START) begin
                    state_n = TX;
                    t_n     = '0;
                    idx_n   = '0;
                    load    = 1'b1;
                end
            end
            FINISH: state_n = START ? FINISH : IDLE;
            default: begin
                t_n = x;
                if (x < l_s) state_n = TX;
                else if (x < w_s) state_n = DELAY;
                else if ({1'b0, x} < wn_s) state_n = ACQ;
                else if (SHOT_IDX == last_s) state_n = FINISH;
                else if (x < si_s) state_n = WAIT;
                else begin
                    state_n = TX;
                    t_n     = '0;
                    idx_n   = SHOT_IDX + 1'b1;
                end
`ifdef ULTRASOUND_SEQ_ABORT_EN
                if (ABORT) begin
                    state_n   = FINISH;
                    idx_n     = SHOT_IDX;
                    abort_hit = 1'b1;
                end
`endif
            end
        endcase
    end

    // state, counters, shadows and registered outputs
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= IDLE;
            t         <= '0;
            SHOT_IDX  <= '0;
            l_s       <= '0;
            w_s       <= '0;
            wn_s      <= '0;
            si_s      <= '0;
            mask_s    <= '0;
            last_s    <= '0;
            TX_EN     <= '0;
            ADC_START <= 1'b0;
            FIFO_EN   <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            OVERFLOW  <= 1'b0;
        end else begin
            state     <= state_n;
            t         <= t_n;
            SHOT_IDX  <= idx_n;
            if (load) begin
                l_s    <= l_in;
                w_s    <= w_in;
                wn_s   <= {1'b0, w_in} + {1'b0, ADC_SAMPLES_PER_ECHO};
                si_s   <= SHOT_INTERVAL;
                mask_s <= TX_CH_MASK;
                last_s <= (NUM_SHOTS == '0) ? '0 : NUM_SHOTS - 1'b1;
            end
            TX_EN     <= (state_n == TX) ? (load ? TX_CH_MASK : mask_s) : '0;
            ADC_START <= (state_n == ACQ) && (state != ACQ);
            FIFO_EN   <= (state_n == ACQ);
            BUSY      <= (state_n != IDLE) && (state_n != FINISH);
            DONE      <= (state_n == FINISH);
            OVERFLOW  <= load ? 1'b0 : (OVERFLOW | (FIFO_EN & FIFO_FULL));
        end
    end

`ifdef ULTRASOUND_SEQ_ABORT_EN
    // abort flag: set when a run is cut short, cleared when the next run starts
    always_ff @(posedge CLK) begin
        if (RESET) ABORTED <= 1'b0;
        else ABORTED <= load ? 1'b0 : (ABORTED | abort_hit);
    end
`else
    logic unused_abort;
    assign unused_abort = abort_hit;
`endif
endmodule
